// File: rtl/shift_rows_stream.sv
// ---------------------------------------------------------------------------
// shift_rows_stream
//
// Byte-serial AES ShiftRows engine. Accepts 16-byte AES states one byte per
// cycle (byte 0 first) and emits the ShiftRows-permuted state, one byte per
// cycle. Two 16-byte banks are used as a ping-pong store so that one state can
// be written while the previous one is read out. This gives a sustained rate
// of 1 byte/cycle.
//
// Parameters:
//   INV      0 = forward ShiftRows (encrypt), 1 = inverse ShiftRows (decrypt)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears all state including banks
//   s_valid  input byte valid
//   s_ready  block can accept an input byte this cycle
//   s_data   input state byte (byte k = bits [8k+7:8k] of the 128-bit state)
//   s_last   asserted with byte 15 of each input state
//   m_valid  output byte valid
//   m_ready  downstream accepts the output byte
//   m_data   permuted state byte, byte 0 first
//   m_last   asserted with output byte 15
//   err      sticky framing-error flag (early or missing s_last)
//
// All outputs are decoded from registers only. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module shift_rows_stream #(
    parameter bit INV = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       err
);

    // Ping-pong storage and per-bank occupancy.
    logic [7:0] bank [2][16];
    logic [1:0] full;

    // Write side.
    logic       wbank;
    logic [3:0] wcnt;

    // Read side.
    logic       rbank;
    logic [3:0] rcnt;

    logic s_fire;
    logic m_fire;
    logic w_done;   // byte 15 of a state is being written
    logic r_done;   // output byte 15 of a state is being read

    // Source byte index for output byte k = 4c + r. The row stays the same.
    // The column is rotated by the row number. The 2-bit column arithmetic
    // gives the mod-4 wrap directly.
    function automatic logic [3:0] src_index(input logic [3:0] k);
        logic [1:0] col;
        col = INV ? (k[3:2] - k[1:0]) : (k[3:2] + k[1:0]);
        return {col, k[1:0]};
    endfunction

    // NOTE: every signal written in an always_comb gets a value on every path.
    // Here each is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        s_ready = !full[wbank];
        m_valid = full[rbank];
        m_data  = bank[rbank][src_index(rcnt)];
        m_last  = full[rbank] && (rcnt == 4'd15);
    end

    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;
    assign w_done = s_fire && (wcnt == 4'd15);
    assign r_done = m_fire && (rcnt == 4'd15);

    // NOTE: the byte store is reset explicitly. A cleared bank makes m_data
    // read 0x00 out of reset. Without this, stale key-dependent data could
    // appear on the idle output. The cost is a reset on every storage flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    bank[b][i] <= 8'h00;
                end
            end
        end else if (s_fire) begin
            // A byte of an early-terminated block is also written here.
            // It is harmless, because that bank never becomes full from it.
            bank[wbank][wcnt] <= s_data;
        end
    end

    // Write control and framing checks.
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples the pre-edge values and the order of the statements
    // below does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank <= 1'b0;
            wcnt  <= 4'd0;
            err   <= 1'b0;
        end else if (s_fire) begin
            if (s_last && (wcnt != 4'd15)) begin
                // Early last: drop the partial block and restart in the same bank.
                wcnt <= 4'd0;
                err  <= 1'b1;
            end else begin
                wcnt <= wcnt + 4'd1;
                if (wcnt == 4'd15) begin
                    wbank <= ~wbank;
                    if (!s_last) begin
                        err <= 1'b1;   // missing last: block still completes
                    end
                end
            end
        end
    end

    // Read control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank <= 1'b0;
            rcnt  <= 4'd0;
        end else if (m_fire) begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) begin
                rbank <= ~rbank;
            end
        end
    end

    // Bank occupancy. A write completion and a read completion in the same
    // cycle always refer to different banks, so both updates apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (r_done) begin
                full[rbank] <= 1'b0;
            end
            if (w_done) begin
                full[wbank] <= 1'b1;
            end
        end
    end

endmodule

// File: doc/shift_rows_stream.md
# shift_rows_stream

Byte-serial AES ShiftRows engine for the encryption datapath. It is the forward-direction counterpart of the 128-bit parallel inverse ShiftRows used on the decryption side. It accepts 16-byte AES states one byte per cycle over a valid/ready stream, buffers them in a two-bank ping-pong store, and emits each state's ShiftRows-permuted bytes on an output stream. It sits between the serial SubBytes stage and MixColumns in the low-area round pipeline. Parameter INV selects the inverse mapping so that the same block can serve the serial decryption path.

## Interface
- INV, 0, 0 = forward ShiftRows (encrypt); 1 = inverse ShiftRows (decrypt)
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous active-low reset; all state is cleared immediately on assertion
- s_valid  input  1  input byte valid
- s_ready  output  1  block can accept an input byte this cycle
- s_data  input  8  input state byte; byte k of the state, with byte k = bits [8k+7:8k] of the 128-bit state, and byte 0 sent first
- s_last  input  1  asserted with byte 15 of each state
- m_valid  output  1  output byte valid
- m_ready  input  1  downstream accepts the output byte
- m_data  output  8  permuted state byte, byte 0 first
- m_last  output  1  asserted with output byte 15
- err  output  1  sticky framing-error flag

## Operation
- Byte index k = 4c + r, where c is the column (0-3) and r is the row (0-3).
- Forward mapping (INV=0): out[4c+r] = in[4((c+r) mod 4)+r]. Full source order for out bytes 0..15: 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
- Inverse mapping (INV=1): out[4c+r] = in[4((c-r) mod 4)+r]. Full source order: 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
- Storage: two banks of 16 bytes, with a full flag per bank (full[0], full[1]).
- Write side state: wbank (1 bit) and wcnt (4 bits).
  - s_ready = !full[wbank].
  - On a transfer (s_valid && s_ready), the byte is written to bank[wbank][wcnt] and wcnt increments, wrapping 15 -> 0.
  - When wcnt == 15 on a transfer: set full[wbank] and toggle wbank.
- Read side state: rbank (1 bit) and rcnt (4 bits).
  - m_valid = full[rbank].
  - m_data = bank[rbank][src(rcnt)], where src() is the mapping table for the selected INV.
  - m_last = m_valid && rcnt == 15.
  - On a transfer (m_valid && m_ready), rcnt increments. When rcnt == 15: clear full[rbank] and toggle rbank.
- Framing:
  - s_last accepted with wcnt != 15 (early last): the partial block is discarded. wcnt returns to 0, the full flag is not set, wbank is unchanged, and err is set.
  - wcnt == 15 accepted with s_last = 0 (missing last): the block completes normally and err is set.
  - err stays set until reset.
- Simultaneous events: a write completion and a read completion in the same cycle always target different banks. Both flag updates take effect.
- INV is static. Only the read-side mux depends on it.

## Timing
- Reset values:
  - s_ready = 1
  - m_valid = 0
  - m_last = 0
  - m_data = 0x00 (banks cleared)
  - err = 0
  - wbank = rbank = 0, wcnt = rcnt = 0
- Latency: byte 15 accepted at edge T gives m_valid = 1 with out byte 0 in the cycle after T.
- Throughput: 1 byte/cycle sustained with continuous s_valid and m_ready. s_ready never deasserts in that case.
- Back-pressure:
  - m_data and m_last hold stable while m_valid && !m_ready.
  - s_ready drops only when both banks are full. It rises in the cycle after the read of out byte 15 completes.
- m_valid, m_data and m_last depend only on registers. s_ready depends only on registers. There are no combinational paths from inputs to outputs.
- Reset mid-block: assertion clears all state asynchronously, and any in-flight bytes are lost. After deassertion the first accepted byte is byte 0 of a new state.

## Test plan
- FIPS-197 vector, INV=0: stream d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 with s_last on 0x30 -> output d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, m_last on e5, err = 0, first output byte in the cycle after the 0x30 transfer.
- INV=1 round trip: feed the INV=0 output above into an INV=1 instance -> original d4 27 11 ... 30 returned byte-exact.
- Back-to-back throughput: 8 consecutive states with continuous s_valid and m_ready = 1 -> 128 output bytes in 128 consecutive cycles, s_ready constantly 1, every output equal to the model.
- Back-pressure: m_ready = 0 while 3 states are offered -> s_ready falls after byte 31 is accepted and m_data holds at byte 0 of state 0. Then m_ready = 1 -> all 48 bytes are correct and in order.
- Framing errors:
  - s_last on byte 6 -> err = 1, nothing output, and the next 16-byte state is output correctly.
  - A state with no s_last -> output normally, err stays 1.
- Reset mid-block: assert rst_n = 0 after 9 bytes of state 1 while state 0 is draining -> m_valid = 0 and s_ready = 1 immediately. After deassertion a fresh FIPS vector produces the correct output.
